// File: rtl/banco_pkg.sv
// Package for banco_de_registradores_param.
// Holds the default geometry, the default reset value and the per-port stall helper.
// Optional build macro: REGFILE_BYPASS_EN (used by the top module only).
package banco_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 4;
  localparam logic [DefaultDataW-1:0] DefaultResetValue = '0;

  // A read port stalls on a registered pending bit unless the write that clears it
  // is being forwarded to this port in the same cycle.
  function automatic logic port_stall(input logic pending, input logic bypass_hit);
    return pending & ~bypass_hit;
  endfunction

endpackage

// File: rtl/banco_de_registradores_param_if.sv
// Decode/writeback bus of the register bank.
// master: the datapath side (drives addresses, requests, write data; samples read results).
// slave:  the register bank.
// Signals: Read_1/Read_2/Signal_read (read request), Data_to_write/Address_to_write/
// Signal_write (writeback), Reserve_addr/Signal_reserve (scoreboard reserve),
// Out_1/Out_2/Out_valid (registered read result), Read_stall (combinational refusal).
interface banco_de_registradores_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] Read_1;
  logic [ADDR_W-1:0] Read_2;
  logic              Signal_read;
  logic [DATA_W-1:0] Data_to_write;
  logic [ADDR_W-1:0] Address_to_write;
  logic              Signal_write;
  logic [ADDR_W-1:0] Reserve_addr;
  logic              Signal_reserve;
  logic [DATA_W-1:0] Out_1;
  logic [DATA_W-1:0] Out_2;
  logic              Out_valid;
  logic              Read_stall;

  modport master (
    output Read_1, Read_2, Signal_read, Data_to_write, Address_to_write, Signal_write,
    output Reserve_addr, Signal_reserve,
    input  Out_1, Out_2, Out_valid, Read_stall
  );

  modport slave (
    input  Read_1, Read_2, Signal_read, Data_to_write, Address_to_write, Signal_write,
    input  Reserve_addr, Signal_reserve,
    output Out_1, Out_2, Out_valid, Read_stall
  );
endinterface

// File: rtl/pending_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reserve, cleared by a write.
// Ports: clk, rst (sync, active high), reserve_en/reserve_addr, clear_en/clear_addr,
// lookup_addr_1/lookup_addr_2 -> pending_1/pending_2 (combinational, registered bits only).
// When ZERO_REG is set, register 0 can never become pending.
module pending_scoreboard #(
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              clear_en,
  input  logic [ADDR_W-1:0] clear_addr,
  input  logic [ADDR_W-1:0] lookup_addr_1,
  input  logic [ADDR_W-1:0] lookup_addr_2,
  output logic              pending_1,
  output logic              pending_2
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clear_en) pending_d[clear_addr] = 1'b0;
    // Reserve applied last: a same-cycle write lands but a new write is still outstanding.
    if (reserve_en) pending_d[reserve_addr] = 1'b1;
    if (ZERO_REG) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_1 = pending_q[lookup_addr_1] & ~(ZERO_REG && (lookup_addr_1 == '0));
  assign pending_2 = pending_q[lookup_addr_2] & ~(ZERO_REG && (lookup_addr_2 == '0));

endmodule

// File: rtl/banco_de_registradores_param.sv
// Parametrised register bank: 2**ADDR_W words of DATA_W bits, two registered read ports,
// one write port, and a pending-write scoreboard that stalls reads of reserved registers.
// Ports: Clock_in, Signal_reset (sync, active high), bus (slave modport of
// banco_de_registradores_param_if).
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data to matching
// read ports and lets such a read through the stall check.
module banco_de_registradores_param
  import banco_pkg::*;
#(
  parameter int unsigned        DATA_W      = DefaultDataW,
  parameter int unsigned        ADDR_W      = DefaultAddrW,
  parameter logic [DATA_W-1:0]  RESET_VALUE = DATA_W'(DefaultResetValue),
  parameter bit                 ZERO_REG    = 1'b0
) (
  input  logic                             Clock_in,
  input  logic                             Signal_reset,
  banco_de_registradores_param_if.slave    bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] out_1_q, out_2_q;
  logic              out_valid_q;

  logic pending_1, pending_2;
  logic hit_1, hit_2;
  logic stall_1, stall_2;
  logic accept;
  logic write_ok;
  logic [DATA_W-1:0] rd_1, rd_2;

  // Writes to a hardwired zero register are dropped.
  assign write_ok = bus.Signal_write & ~(ZERO_REG && (bus.Address_to_write == '0));

  pending_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (Clock_in),
    .rst           (Signal_reset),
    .reserve_en    (bus.Signal_reserve),
    .reserve_addr  (bus.Reserve_addr),
    .clear_en      (bus.Signal_write),
    .clear_addr    (bus.Address_to_write),
    .lookup_addr_1 (bus.Read_1),
    .lookup_addr_2 (bus.Read_2),
    .pending_1     (pending_1),
    .pending_2     (pending_2)
  );

`ifdef REGFILE_BYPASS_EN
  assign hit_1 = write_ok && (bus.Address_to_write == bus.Read_1);
  assign hit_2 = write_ok && (bus.Address_to_write == bus.Read_2);
`else
  assign hit_1 = 1'b0;
  assign hit_2 = 1'b0;
`endif

  assign stall_1        = port_stall(pending_1, hit_1);
  assign stall_2        = port_stall(pending_2, hit_2);
  assign bus.Read_stall = bus.Signal_read & (stall_1 | stall_2);
  assign accept         = bus.Signal_read & ~bus.Read_stall;

  assign rd_1 = hit_1 ? bus.Data_to_write : mem_q[bus.Read_1];
  assign rd_2 = hit_2 ? bus.Data_to_write : mem_q[bus.Read_2];

  always_ff @(posedge Clock_in) begin
    if (Signal_reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
      end
      out_1_q     <= '0;
      out_2_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (write_ok) mem_q[bus.Address_to_write] <= bus.Data_to_write;
      if (accept) begin
        out_1_q <= rd_1;
        out_2_q <= rd_2;
      end
      out_valid_q <= accept;
    end
  end

  assign bus.Out_1     = out_1_q;
  assign bus.Out_2     = out_2_q;
  assign bus.Out_valid = out_valid_q;

endmodule

// File: tb/tb_banco_de_registradores_param.sv
// Directed, table-driven bench for banco_de_registradores_param.
// Two instances: default (ZERO_REG=0) and a hardwired-zero build (ZERO_REG=1).
// Expectations depend on REGFILE_BYPASS_EN where the two builds differ.
module tb_banco_de_registradores_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    logic          rst;
    logic          rd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rsv;
    logic [AW-1:0] ra;
    logic          e_stall;
    logic          e_valid;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_z = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  banco_de_registradores_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  banco_de_registradores_param_if #(.DATA_W(DW), .ADDR_W(AW)) zbus ();

  banco_de_registradores_param #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .RESET_VALUE (32'h0),
    .ZERO_REG    (1'b0)
  ) dut (
    .Clock_in     (clk),
    .Signal_reset (rst_a),
    .bus          (bus)
  );

  banco_de_registradores_param #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .RESET_VALUE (32'h0),
    .ZERO_REG    (1'b1)
  ) dut_z (
    .Clock_in     (clk),
    .Signal_reset (rst_z),
    .bus          (zbus)
  );

  function automatic vec_t mk(input logic rst, input logic rd, input logic [AW-1:0] r1,
                              input logic [AW-1:0] r2, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic rsv, input logic [AW-1:0] ra,
                              input logic es, input logic ev, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2);
    vec_t v;
    v.rst = rst; v.rd = rd; v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa; v.wd = wd;
    v.rsv = rsv; v.ra = ra; v.e_stall = es; v.e_valid = ev; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx, input bit z);
    @(negedge clk);
    if (z) begin
      rst_z = v.rst;
      zbus.Signal_read = v.rd; zbus.Read_1 = v.r1; zbus.Read_2 = v.r2;
      zbus.Signal_write = v.we; zbus.Address_to_write = v.wa; zbus.Data_to_write = v.wd;
      zbus.Signal_reserve = v.rsv; zbus.Reserve_addr = v.ra;
    end else begin
      rst_a = v.rst;
      bus.Signal_read = v.rd; bus.Read_1 = v.r1; bus.Read_2 = v.r2;
      bus.Signal_write = v.we; bus.Address_to_write = v.wa; bus.Data_to_write = v.wd;
      bus.Signal_reserve = v.rsv; bus.Reserve_addr = v.ra;
    end
    #1;
    chk(z ? "z_stall" : "stall", idx, DW'(z ? zbus.Read_stall : bus.Read_stall),
        DW'(v.e_stall));
    @(posedge clk);
    #1;
    chk(z ? "z_valid" : "valid", idx, DW'(z ? zbus.Out_valid : bus.Out_valid),
        DW'(v.e_valid));
    chk(z ? "z_out1" : "out1", idx, z ? zbus.Out_1 : bus.Out_1, v.e1);
    chk(z ? "z_out2" : "out2", idx, z ? zbus.Out_2 : bus.Out_2, v.e2);
  endtask

  vec_t va[22];
  vec_t vz[8];

  initial begin
    bus.Signal_read = 1'b0; bus.Read_1 = '0; bus.Read_2 = '0; bus.Signal_write = 1'b0;
    bus.Address_to_write = '0; bus.Data_to_write = '0; bus.Signal_reserve = 1'b0;
    bus.Reserve_addr = '0;
    zbus.Signal_read = 1'b0; zbus.Read_1 = '0; zbus.Read_2 = '0; zbus.Signal_write = 1'b0;
    zbus.Address_to_write = '0; zbus.Data_to_write = '0; zbus.Signal_reserve = 1'b0;
    zbus.Reserve_addr = '0;

    //           rst  rd  r1  r2  we  wa  wd        rsv ra  stall vld  out1      out2
    va[0]  = mk(1'b1, 0,  0,  0,  1,  2,  32'h9,    0,  0,  0,    0,   32'h0,    32'h0);
    va[1]  = mk(1'b0, 1,  0,  1,  0,  0,  32'h0,    0,  0,  0,    1,   32'h0,    32'h0);
    va[2]  = mk(1'b0, 1,  2,  2,  0,  0,  32'h0,    0,  0,  0,    1,   32'h0,    32'h0);
    va[3]  = mk(1'b0, 0,  0,  0,  1,  0,  32'h1,    0,  0,  0,    0,   32'h0,    32'h0);
    va[4]  = mk(1'b0, 1,  0,  0,  0,  0,  32'h0,    0,  0,  0,    1,   32'h1,    32'h1);
    va[5]  = mk(1'b0, 1,  0,  7,  1,  7,  32'h7,    0,  0,  0,    1,   32'h1,
                Bypass ? 32'h7 : 32'h0);
    va[6]  = mk(1'b0, 1,  0,  7,  0,  0,  32'h0,    0,  0,  0,    1,   32'h1,    32'h7);
    // Reserve in the same cycle as a read of that register does not stall it.
    va[7]  = mk(1'b0, 1,  3,  0,  0,  0,  32'h0,    1,  3,  0,    1,   32'h0,    32'h1);
    va[8]  = mk(1'b0, 1,  3,  0,  0,  0,  32'h0,    0,  0,  1,    0,   32'h0,    32'h1);
    va[9]  = mk(1'b0, 1,  0,  3,  0,  0,  32'h0,    0,  0,  1,    0,   32'h0,    32'h1);
    va[10] = mk(1'b0, 1,  3,  0,  1,  3,  32'hA5,   0,  0,  !Bypass, Bypass,
                Bypass ? 32'hA5 : 32'h0, 32'h1);
    va[11] = mk(1'b0, 1,  3,  0,  0,  0,  32'h0,    0,  0,  0,    1,   32'hA5,   32'h1);
    va[12] = mk(1'b0, 0,  0,  0,  1,  5,  32'h55,   1,  5,  0,    0,   32'hA5,   32'h1);
    va[13] = mk(1'b0, 1,  5,  5,  0,  0,  32'h0,    0,  0,  1,    0,   32'hA5,   32'h1);
    va[14] = mk(1'b0, 0,  0,  0,  1,  5,  32'h66,   0,  0,  0,    0,   32'hA5,   32'h1);
    va[15] = mk(1'b0, 1,  5,  1,  0,  0,  32'h0,    0,  0,  0,    1,   32'h66,   32'h0);
    va[16] = mk(1'b0, 1,  9,  9,  1,  9,  32'h99,   0,  0,  0,    1,
                Bypass ? 32'h99 : 32'h0, Bypass ? 32'h99 : 32'h0);
    va[17] = mk(1'b0, 1,  9,  7,  0,  0,  32'h0,    0,  0,  0,    1,   32'h99,   32'h7);
    va[18] = mk(1'b0, 0,  0,  0,  0,  0,  32'h0,    1,  4,  0,    0,   32'h99,   32'h7);
    va[19] = mk(1'b0, 1,  4,  4,  0,  0,  32'h0,    0,  0,  1,    0,   32'h99,   32'h7);
    // Reset while stalled: stall is still combinationally visible, state is cleared.
    va[20] = mk(1'b1, 1,  4,  4,  0,  0,  32'h0,    0,  0,  1,    0,   32'h0,    32'h0);
    va[21] = mk(1'b0, 1,  4,  7,  0,  0,  32'h0,    0,  0,  0,    1,   32'h0,    32'h0);

    vz[0]  = mk(1'b1, 0,  0,  0,  0,  0,  32'h0,    0,  0,  0,    0,   32'h0,    32'h0);
    vz[1]  = mk(1'b0, 0,  0,  0,  1,  0,  32'hFF,   1,  0,  0,    0,   32'h0,    32'h0);
    vz[2]  = mk(1'b0, 1,  0,  0,  0,  0,  32'h0,    0,  0,  0,    1,   32'h0,    32'h0);
    vz[3]  = mk(1'b0, 0,  0,  0,  1,  2,  32'h12,   1,  2,  0,    0,   32'h0,    32'h0);
    vz[4]  = mk(1'b0, 1,  2,  0,  0,  0,  32'h0,    0,  0,  1,    0,   32'h0,    32'h0);
    vz[5]  = mk(1'b1, 1,  2,  0,  0,  0,  32'h0,    0,  0,  1,    0,   32'h0,    32'h0);
    vz[6]  = mk(1'b0, 1,  2,  0,  0,  0,  32'h0,    0,  0,  0,    1,   32'h0,    32'h0);
    // A write to register 0 is never forwarded, bypass or not.
    vz[7]  = mk(1'b0, 1,  0,  0,  1,  0,  32'hAB,   0,  0,  0,    1,   32'h0,    32'h0);

    for (int i = 0; i < 22; i++) run(va[i], i, 1'b0);
    for (int i = 0; i < 8; i++) run(vz[i], i, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
